// File: rtl/gcn_pkg.sv
// Shared parameters and types for the GCN aggregation datapath.
package gcn_pkg;

    localparam int unsigned NUM_OF_NODES   = 6;
    localparam int unsigned NUM_EDGES      = 6;
    localparam int unsigned WEIGHT_COLS    = 3;
    localparam int unsigned DOT_PROD_WIDTH = 16;

    localparam int unsigned NODE_BW = $clog2(NUM_OF_NODES);
    // Edge pointer must reach NUM_EDGES itself, the "list exhausted" value.
    localparam int unsigned COO_BW  = $clog2(NUM_EDGES + 1);

    typedef logic [DOT_PROD_WIDTH-1:0] elem_t;
    typedef elem_t                     row_t [WEIGHT_COLS];
    typedef logic [NODE_BW-1:0]        node_t;
    typedef logic [COO_BW-1:0]         coo_ptr_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } agg_state_t;

endpackage

// File: rtl/coo_aggregate_if.sv
// Bus bundle between coo_aggregate, the COO/FM_WM memories, FM_WM_ADJ and ARG_MAX.
interface coo_aggregate_if
    import gcn_pkg::*;
();

    logic     start;
    coo_ptr_t coo_address;
    node_t    coo_row_in;
    node_t    coo_col_in;
    node_t    fm_wm_read_row;
    row_t     fm_wm_row_in;
    logic     adj_wr_en;
    node_t    adj_write_row;
    row_t     adj_row_out;
    logic     busy;
    logic     done;
    logic     order_err;

    modport slave (
        input  start, coo_row_in, coo_col_in, fm_wm_row_in,
        output coo_address, fm_wm_read_row, adj_wr_en, adj_write_row,
               adj_row_out, busy, done, order_err
    );

    modport master (
        output start, coo_row_in, coo_col_in, fm_wm_row_in,
        input  coo_address, fm_wm_read_row, adj_wr_en, adj_write_row,
               adj_row_out, busy, done, order_err
    );

endinterface

// File: rtl/coo_aggregate_row_vec_add.sv
// Element-wise wrapping adder over one WEIGHT_COLS-wide row.
module row_vec_add
    import gcn_pkg::*;
(
    input  row_t a,
    input  row_t b,
    output row_t sum
);

    always_comb begin
        sum = '{default: '0};
        for (int unsigned k = 0; k < WEIGHT_COLS; k++) begin
            sum[k] = a[k] + b[k];
        end
    end

endmodule

// File: rtl/coo_aggregate.sv
// Walks a row-sorted COO edge list, summing FM_WM rows per destination node
// and emitting one FM_WM_ADJ row per node.
module coo_aggregate
    import gcn_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    coo_aggregate_if.slave  bus
);

    agg_state_t state;
    agg_state_t state_next;

    node_t    r;
    coo_ptr_t e;
    row_t     acc;
    row_t     acc_sum;
    logic     order_err_q;

    logic edge_valid;
    logic do_clear;
    logic do_add;
    logic do_skip;
    logic do_write;

    row_vec_add u_row_vec_add (
        .a   (acc),
        .b   (bus.fm_wm_row_in),
        .sum (acc_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs feeding the combinational memory reads stay out of the decision
    // block so the address -> data -> decision path has no false loop.
    always_comb begin
        state_next = state;
        do_clear   = 1'b0;
        do_add     = 1'b0;
        do_skip    = 1'b0;
        do_write   = 1'b0;
        edge_valid = (e < coo_ptr_t'(NUM_EDGES));

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = ACCUM;
                    do_clear   = 1'b1;
                end
            end
            ACCUM: begin
                if (edge_valid && (bus.coo_row_in == r)) begin
                    do_add = 1'b1;
                end else if (edge_valid && (bus.coo_row_in < r)) begin
                    do_skip = 1'b1;
                end else begin
                    do_write = 1'b1;
                    if (r == node_t'(NUM_OF_NODES - 1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r           <= '0;
            e           <= '0;
            acc         <= '{default: '0};
            order_err_q <= 1'b0;
        end else if (do_clear) begin
            r           <= '0;
            e           <= '0;
            acc         <= '{default: '0};
            order_err_q <= 1'b0;
        end else begin
            if (do_add) begin
                acc <= acc_sum;
                e   <= e + coo_ptr_t'(1);
            end
            if (do_skip) begin
                e           <= e + coo_ptr_t'(1);
                order_err_q <= 1'b1;
            end
            if (do_write) begin
                acc <= '{default: '0};
                r   <= r + node_t'(1);
            end
        end
    end

    assign bus.coo_address    = e;
    assign bus.fm_wm_read_row = (state == ACCUM) ? bus.coo_col_in : '0;
    assign bus.adj_wr_en      = do_write;
    assign bus.adj_write_row  = r;
    assign bus.adj_row_out    = acc;
    assign bus.busy           = (state == ACCUM);
    assign bus.done           = (state == DONE);
    assign bus.order_err      = order_err_q;

endmodule

// File: doc/coo_aggregate.md
Name: coo_aggregate

Overview:
- Computes the sparse product ADJ x (FM x WM), one output row per graph node.
- Walks the COO edge list. For each edge (row, col) it adds FM_WM row `col` into an accumulator for row `row`.
- Writes every completed accumulator row, zero rows included, to the FM_WM_ADJ memory.
- Sits between the FM_WM memory and ARG_MAX. Its `done` drives ARG_MAX's `start`.

Parameters:
- NUM_OF_NODES, 6, graph nodes, equal to the number of output rows.
- NUM_EDGES, 6, COO entries (COO_NUM_OF_COLS).
- WEIGHT_COLS, 3, elements per FM_WM row.
- DOT_PROD_WIDTH, 16, element width, unsigned.
- NODE_BW, $clog2(NUM_OF_NODES), row/column index width.
- COO_BW, $clog2(NUM_EDGES+1), edge pointer width; it must be able to hold NUM_EDGES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin aggregation; sampled only in IDLE.
- coo_address  out  COO_BW  current edge pointer.
- coo_row_in  in  NODE_BW  destination row of the edge at coo_address; combinational read.
- coo_col_in  in  NODE_BW  source column of the edge at coo_address; combinational read.
- fm_wm_read_row  out  NODE_BW  equals coo_col_in while in ACCUM, else 0.
- fm_wm_row_in  in  WEIGHT_COLS x DOT_PROD_WIDTH  FM_WM row at fm_wm_read_row; combinational.
- adj_wr_en  out  1  write strobe to the FM_WM_ADJ memory.
- adj_write_row  out  NODE_BW  row being written (current node r).
- adj_row_out  out  WEIGHT_COLS x DOT_PROD_WIDTH  accumulator contents.
- busy  out  1  high in ACCUM.
- done  out  1  high in DONE.
- order_err  out  1  sticky; set when a COO entry has row < r.

Behaviour:
- States:
  - IDLE: start=1 goes to ACCUM; r, e and acc are all cleared.
  - ACCUM: one action per cycle, see below.
  - DONE: holds until start=0, then goes to IDLE.
- ACCUM actions, in priority order:
  1. If e < NUM_EDGES and coo_row_in == r: acc[k] += fm_wm_row_in[k] for each k, mod 2^DOT_PROD_WIDTH (wraps, no saturation). Then e++.
  2. If e < NUM_EDGES and coo_row_in < r: skip the entry, e++, set order_err.
  3. Otherwise, when e == NUM_EDGES or coo_row_in > r:
     - assert adj_wr_en with adj_write_row=r and adj_row_out=acc;
     - clear acc, r++;
     - if r == NUM_OF_NODES-1, the next state is DONE.
- adj_wr_en is combinational: it depends on state, e, r and coo_row_in. The memory captures the row on the rising edge.
- COO entries must be sorted by row. Duplicate edges accumulate twice. Self-loops are ordinary entries.
- A node with no edges is written as all zeros.
- Latency: exactly NUM_EDGES + NUM_OF_NODES cycles in ACCUM. done rises on the following edge and stays high while start is high.
- A start pulse while in ACCUM is ignored.
- Reset values (asynchronous, reset=0), applying at any time including mid-ACCUM:
  - state=IDLE;
  - r=0, e=0, acc=0;
  - done=0, busy=0, adj_wr_en=0, order_err=0;
  - coo_address=0, fm_wm_read_row=0, adj_write_row=0.
  - Partial memory writes are not undone.
- order_err clears only on reset or on IDLE->ACCUM.
- coo_address=e. When e == NUM_EDGES, the COO data is ignored.

Decomposition:
- gcn_pkg holds:
  - the shared parameters (NUM_OF_NODES, NUM_EDGES, WEIGHT_COLS, DOT_PROD_WIDTH);
  - typedef row_t, an array [WEIGHT_COLS] of logic [DOT_PROD_WIDTH-1:0];
  - typedef agg_state_t, an enum {IDLE, ACCUM, DONE}.
- One sub-module, row_vec_add: a combinational WEIGHT_COLS-wide wrapping adder. It can be reused by later layers.

Test Plan:
- FM_WM row c = {c,2c,3c}. Edges (0,0),(0,1),(1,1),(2,3),(2,4),(5,5). Pulse start ->
  - writes: row0={1,2,3}, row1={1,2,3}, row2={7,14,21}, row3={0,0,0}, row4={0,0,0}, row5={5,10,15};
  - exactly 12 busy cycles, then done; order_err=0.
- All 6 edges are (3,2) with row2={40000,1,1} -> row3 = {(240000 mod 65536)=43392, 6, 6}; every other row is 0.
- Unsorted list (1,0),(0,0),(1,1),... -> order_err=1 and the (0,0) entry is not added to any row; rows are still written in order 0..5.
- reset driven low in the 4th ACCUM cycle -> all outputs are 0 immediately (asynchronously). A new start then reproduces the results of the first scenario.
- start held high through DONE -> done stays high and there is no re-run. start dropped -> IDLE. Re-pulse -> identical 12-cycle run.
- start pulsed during ACCUM -> no effect on results or on cycle count.
